// File: rtl/octa10g_mdio_scheduler.sv
// octa10g_mdio_scheduler: MDIO master that round-robin polls a link bit on eight PHY lanes and
// interleaves host register transactions with strict alternation under contention.
module octa10g_mdio_scheduler #(
  parameter int          CLK_DIV    = 32,
  parameter logic [4:0]  POLL_DEVAD = 5'd3,
  parameter logic [15:0] POLL_REGAD = 16'h0020,
  parameter int          POLL_BIT   = 12,
  parameter logic [4:0]  PRTAD      = 5'd0
) (
  input  logic        clk156_i,
  input  logic        reset_i,
  output logic        mdc_o,
  output logic        mdio_o,
  input  logic        mdio_i,
  output logic [2:0]  mdio_sel_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [2:0]  host_lane_i,
  input  logic [4:0]  host_devad_i,
  input  logic [15:0] host_regad_i,
  input  logic [15:0] host_wdata_i,
  output logic        host_ack_o,
  output logic [15:0] host_rdata_o,
  output logic [7:0]  link_status_o,
  output logic        link_change_o
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [5:0] bitc;
  logic [2:0] ptr;
  logic [4:0] devad;
  logic [15:0] regad, wdata, sh;
  logic [63:0] frame;
  logic is_host, last_host, we, active, bit_end, frame_end, xfer_end, host_win;
  assign active    = state == ADDR || state == XFER;
  assign bit_end   = active && cnt == LAST;
  assign frame_end = bit_end && bitc == 6'd63;
  assign xfer_end  = frame_end && state == XFER;
  assign host_win  = host_req_i && !last_host;
  assign mdc_o     = active && cnt >= HALF;
  // Read frames release the line (all ones) through turnaround and data.
  assign frame = state == ADDR ? {32'hFFFF_FFFF, 4'b0000, PRTAD, devad, 2'b10, regad}
               : we ? {32'hFFFF_FFFF, 4'b0001, PRTAD, devad, 2'b10, wdata}
               : {32'hFFFF_FFFF, 4'b0011, PRTAD, devad, 18'h3FFFF};
  assign mdio_o = active ? frame[~bitc] : 1'b1;
  always_comb begin
    state_n = state == IDLE ? ADDR : state == DONE ? IDLE : !frame_end ? state : state == ADDR ? XFER : DONE;
  end
  always_ff @(posedge clk156_i) begin
    if (reset_i) begin
      state         <= IDLE;
      cnt           <= '0;
      bitc          <= '0;
      ptr           <= '0;
      last_host     <= 1'b0;
      is_host       <= 1'b0;
      we            <= 1'b0;
      devad         <= '0;
      regad         <= '0;
      wdata         <= '0;
      sh            <= '0;
      mdio_sel_o    <= '0;
      host_ack_o    <= 1'b0;
      host_rdata_o  <= '0;
      link_status_o <= '0;
      link_change_o <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= bit_end || !active ? '0 : cnt + CW'(1);
      bitc          <= frame_end || !active ? '0 : bitc + 6'(bit_end);
      host_ack_o    <= xfer_end && is_host;
      link_change_o <= xfer_end && !is_host && link_status_o[mdio_sel_o] != sh[POLL_BIT];
      // A poll is always pending, so every IDLE cycle is a grant.
      if (state == IDLE) begin
        is_host    <= host_win;
        last_host  <= host_win;
        we         <= host_win && host_we_i;
        mdio_sel_o <= host_win ? host_lane_i : ptr;
        devad      <= host_win ? host_devad_i : POLL_DEVAD;
        regad      <= host_win ? host_regad_i : POLL_REGAD;
        wdata      <= host_wdata_i;
      end
      if (state == XFER && cnt == HALF) sh <= {sh[14:0], mdio_i};
      if (xfer_end && is_host && !we) host_rdata_o <= sh;
      if (xfer_end && !is_host) link_status_o[mdio_sel_o] <= sh[POLL_BIT];
      if (state == DONE && !is_host) ptr <= ptr + 3'd1;
    end
  end
endmodule

// File: tb/tb_octa10g_mdio_scheduler.sv
// tb_octa10g_mdio_scheduler: scoreboard bench with an eight-lane PHY model; every completed
// transaction is checked for lane, bitstream, latency, ack and read/status results.
module tb_octa10g_mdio_scheduler;
  logic clk = 0, reset = 1, mdc, mdio_o, mdio_i, req = 0, we = 0, ack, chg;
  logic [2:0] sel, lane = 0;
  logic [4:0] devad = 0;
  logic [15:0] regad = 0, wdata = 0, rdata;
  logic [7:0] status;
  typedef struct {
    bit           host;
    logic [2:0]   lane;
    logic [127:0] frame;
    logic [15:0]  rdata;
    logic         chg;
    logic [7:0]   st;
  } exp_t;
  exp_t q[$];
  logic [15:0] lane_val [8];
  logic [7:0] exp_st = 0;
  logic [15:0] exp_rd = 0;
  logic [127:0] cap = 0;
  logic mprev = 0, rst_seen = 0;
  int n_vec = 0, n_bad = 0, cyc = 0, t_grant = 0, pos = 0, ack_cnt = 0, chg_cnt = 0, base;
  localparam logic [31:0] PRE = 32'hFFFF_FFFF;

  octa10g_mdio_scheduler #(.CLK_DIV(2)) dut (
    .clk156_i(clk), .reset_i(reset), .mdc_o(mdc), .mdio_o(mdio_o), .mdio_i(mdio_i),
    .mdio_sel_o(sel), .host_req_i(req), .host_we_i(we), .host_lane_i(lane),
    .host_devad_i(devad), .host_regad_i(regad), .host_wdata_i(wdata), .host_ack_o(ack),
    .host_rdata_o(rdata), .link_status_o(status), .link_change_o(chg)
  );

  always #5 clk = ~clk;

  // PHY model: drives the selected lane's data during the last 16 bits of the second frame.
  assign mdio_i = pos >= 112 ? lane_val[sel][4'(127 - pos)] : 1'b1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pos = 0;
        mprev = 0;
        rst_seen = 1;
        cap = 0;
      end else begin
        if (rst_seen) begin
          t_grant = cyc;
          rst_seen = 0;
        end
        if (ack) ack_cnt++;
        if (chg) chg_cnt++;
        if (mdc && !mprev) cap = {cap[126:0], mdio_o};
        if (!mdc && mprev) begin
          pos++;
          if (pos == 128) begin
            if (q.size() == 0) chk("unexpected_ack", ack, 0);
            else begin
              e = q.pop_front();
              chk("lane", sel, e.lane);
              chk("frame", cap, e.frame);
              chk("latency", cyc - t_grant, 513);
              chk("ack", ack, e.host);
              if (e.host) chk("rdata", rdata, e.rdata);
              else begin
                chk("status", status, e.st);
                chk("change", chg, e.chg);
              end
            end
            pos = 0;
            t_grant = cyc + 1;
          end
        end
        mprev = mdc;
      end
    end
  end

  task automatic push_poll(input logic [2:0] l);
    exp_t e;
    logic b;
    b = lane_val[l][12];
    e.host = 0;
    e.lane = l;
    e.frame = {PRE, 4'b0000, 5'd0, 5'd3, 2'b10, 16'h0020, PRE, 4'b0011, 5'd0, 5'd3, 18'h3FFFF};
    e.rdata = 0;
    e.chg = exp_st[l] != b;
    exp_st[l] = b;
    e.st = exp_st;
    q.push_back(e);
  endtask

  task automatic push_host(input logic w, input logic [2:0] l, input logic [4:0] d,
                           input logic [15:0] r, input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.host = 1;
    e.lane = l;
    e.frame = {PRE, 4'b0000, 5'd0, d, 2'b10, r,
               w ? {PRE, 4'b0001, 5'd0, d, 2'b10, wd} : {PRE, 4'b0011, 5'd0, d, 18'h3FFFF}};
    if (!w) exp_rd = rd;
    e.rdata = exp_rd;
    e.chg = 0;
    e.st = exp_st;
    q.push_back(e);
  endtask

  task automatic set_host(input logic w, input logic [2:0] l, input logic [4:0] d,
                          input logic [15:0] r, input logic [15:0] wd);
    we = w;
    lane = l;
    devad = d;
    regad = r;
    wdata = wd;
    req = 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
    chk("rst_mdc", mdc, 0);
    chk("rst_mdio", mdio_o, 1);
    chk("rst_sel", sel, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_status", status, 0);
    chk("rst_change", chg, 0);
    reset = 0;
    q.delete();
    exp_st = 0;
    exp_rd = 0;
    chg_cnt = 0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Host transaction; inputs are scrambled after the grant to show they are held internally.
  task automatic run_host(input logic w, input logic [2:0] l, input logic [4:0] d,
                          input logic [15:0] r, input logic [15:0] wd, input logic [15:0] rd);
    int n = 0;
    push_host(w, l, d, r, wd, rd);
    set_host(w, l, d, r, wd);
    repeat (20) @(posedge clk);
    #1 set_host(~w, ~l, ~d, ~r, ~wd);
    while (!ack && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!ack) chk("ack_timeout", 0, 1);
    @(posedge clk);
    #1 req = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) lane_val[i] = 16'h0000;
    lane_val[0] = 16'h1000;
    lane_val[5] = 16'h1000;
    repeat (3) @(posedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) push_poll(3'(i));
    wait_empty(6000);
    chk("status_after_round", status, 8'h21);
    chk("change_pulses", chg_cnt, 2);
    lane_val[2] = 16'h1000;
    push_poll(1);
    push_poll(2);
    wait_empty(1500);
    chk("lane2_set", status, 8'h25);
    lane_val[2] = 16'h0000;
    for (int i = 3; i < 11; i++) push_poll(3'(i));
    wait_empty(5000);
    chk("lane2_cleared", status, 8'h21);
    chk("change_total", chg_cnt, 4);

    do_reset();
    lane_val[3] = 16'hBEEF;
    run_host(0, 3, 5'd1, 16'h0007, 16'h0000, 16'hBEEF);
    push_poll(0);
    wait_empty(1200);
    push_poll(1);
    wait_empty(1200);
    run_host(1, 6, 5'd1, 16'h0000, 16'hA55A, 16'h0000);
    chk("write_keeps_rdata", rdata, 16'hBEEF);

    do_reset();
    lane_val[4] = 16'h1234;
    base = ack_cnt;
    push_host(0, 4, 5'd2, 16'h0011, 16'h0000, 16'h1234);
    push_poll(0);
    push_host(0, 4, 5'd2, 16'h0011, 16'h0000, 16'h1234);
    push_poll(1);
    set_host(0, 4, 5'd2, 16'h0011, 16'h0000);
    for (int n = 0; n < 3000 && ack_cnt < base + 2; n++) @(negedge clk);
    req = 0;
    wait_empty(1200);
    chk("alternation_acks", ack_cnt - base, 2);

    do_reset();
    lane_val[7] = 16'hCAFE;
    push_host(0, 7, 5'd4, 16'h0100, 16'h0000, 16'hCAFE);
    set_host(0, 7, 5'd4, 16'h0100, 16'h0000);
    repeat (300) @(posedge clk);
    base = ack_cnt;
    do_reset();
    chk("abort_no_ack", ack_cnt - base, 0);
    run_host(0, 7, 5'd4, 16'h0100, 16'h0000, 16'hCAFE);
    wait_empty(100);
    chk("reissue_rdata", rdata, 16'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/octa10g_mdio_scheduler.md
OCTA10G_MDIO_SCHEDULER -- requirements
Module: octa10g_mdio_scheduler

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- CLK_DIV, 32, clk156_i cycles per MDC half-period (>=2).
- POLL_DEVAD, 5'd3, device address polled on every lane.
- POLL_REGAD, 16'h0020, register address polled.
- POLL_BIT, 12, read-data bit mirrored into link_status_o.
- PRTAD, 5'd0, port address placed in every frame.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk156_i, in, 1, sole clock.
- reset_i, in, 1, synchronous active-high reset.
- mdc_o, out, 1, MDIO management clock to PHY lanes.
- mdio_o, out, 1, serial data to PHY (idle/released = 1).
- mdio_i, in, 1, serial data from selected PHY lane.
- mdio_sel_o, out, 3, lane selected for current transaction.
- host_req_i, in, 1, host transaction request, held until ack.
- host_we_i, in, 1, 1 = write, 0 = read.
- host_lane_i, in, 3, target lane.
- host_devad_i, in, 5, device address.
- host_regad_i, in, 16, register address.
- host_wdata_i, in, 16, write data.
- host_ack_o, out, 1, one-cycle completion pulse.
- host_rdata_o, out, 16, read data, valid with ack, held until next ack.
- link_status_o, out, 8, per-lane polled status bit.
- link_change_o, out, 1, one-cycle pulse when any link_status_o bit changes.
REQ-003 SHALL use one clock, clk156_i; reset_i is synchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, ADDR, XFER, DONE; IDLE->ADDR on grant, ADDR->XFER after 64 bits, XFER->DONE after 64 bits, DONE->IDLE unconditionally.
REQ-005 SHALL always have a poll request pending; arbitration in IDLE: host wins unless previous grant was host, in which case poll wins (strict alternation under contention).
REQ-006 SHALL sample host_we/lane/devad/regad/wdata in the grant cycle and hold them internally for the transaction; later input changes are ignored.
REQ-007 SHALL poll lanes round-robin 0..7, wrapping 7->0; the poll pointer advances only in a poll DONE.
REQ-008 SHALL hold mdio_sel_o constant from the cycle after grant through DONE.
REQ-009 SHALL form each bit period as 2*CLK_DIV cycles: mdc_o low for the first CLK_DIV, high for the second; mdc_o stays 0 in IDLE/DONE.
REQ-010 SHALL change mdio_o only at bit-period start; SHALL sample mdio_i in the cycle mdc_o goes high.
REQ-011 SHALL send an ADDR frame: 32 ones, ST=00, OP=00, PRTAD, DEVAD, TA=10, 16-bit register address, MSB first.
REQ-012 SHALL send an XFER frame: 32 ones, ST=00, OP=01 (write) or 11 (read), PRTAD, DEVAD, then TA=10 plus wdata for writes, or mdio_o=1 during TA and 16 data bits for reads, with mdio_i shifted in MSB first.
REQ-013 SHALL enter DONE exactly 1+128*2*CLK_DIV cycles after the grant cycle.
REQ-014 For a host transaction in DONE: host_ack_o=1 for one cycle; host_rdata_o updated on reads, unchanged on writes.
REQ-015 For a poll in DONE: link_status_o[lane] <= rdata[POLL_BIT]; link_change_o=1 in the same cycle if the bit changed; host_ack_o stays 0.
REQ-016 SHALL never ack a host request that was not granted; host_req_i deasserting mid-transaction does not abort it.

Reset
REQ-017 On reset_i: state IDLE, mdc_o=0, mdio_o=1, mdio_sel_o=0, poll pointer 0, last-grant=poll, host_ack_o=0, host_rdata_o=0, link_status_o=0, link_change_o=0.
REQ-018 Reset mid-transaction SHALL abort without ack or status update; first grant after release goes to the host if host_req_i=1, else polls lane 0.

Verification (CLK_DIV=2; bit=4 cycles; transaction 513 cycles grant-to-DONE)
REQ-019 No host request, lane model returns 16'h1000 on lanes 0 and 5 only -> polls 0..7 in order, wrap to 0; link_status_o=8'h21; link_change_o pulses exactly twice.
REQ-020 Host read lane 3, devad 1, regad 16'h0007, model returns 16'hBEEF -> mdio_sel_o=3, ADDR bitstream checked bit-exact, ack 513 cycles after grant, host_rdata_o=16'hBEEF.
REQ-021 Host write lane 6, devad 1, regad 16'h0000, wdata 16'hA55A -> XFER OP=01, TA=10, data bits A55A MSB-first on mdio_o; ack pulse; host_rdata_o unchanged.
REQ-022 host_req_i held high for 4 transactions -> grants alternate host, poll, host, poll; exactly 2 acks.
REQ-023 reset_i pulsed at cycle 300 of a host read -> no ack, outputs at reset values next cycle, mdio_o=1, mdc_o=0; re-issued request completes normally.
REQ-024 Lane 2 status toggles 1->0 between polls -> link_status_o[2] clears in lane-2 poll DONE with one link_change_o pulse.
